// File: rtl/poly_cfg_pkg.sv
// Shared definitions for the polygon command loader: field widths, command
// opcodes, loader state encoding and the per-slot polygon descriptor.
package poly_cfg_pkg;

  localparam int NUM_POLY = 2;
  localparam int XW       = 7;
  localparam int YW       = 6;
  localparam int CW       = 6;
  localparam int DW       = 3;

  // Header opcodes, taken from bits [7:6] of a header byte
  localparam logic [1:0] OP_SET_BG     = 2'b00;
  localparam logic [1:0] OP_WRITE_POLY = 2'b01;
  localparam logic [1:0] OP_DISABLE    = 2'b10;
  localparam logic [1:0] OP_COMMIT     = 2'b11;

  // Index of the final data byte (depth) of a WRITE_POLY command
  localparam logic [2:0] LAST_DATA_IDX = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_DATA      = 2'b01,
    ST_WAIT_SWAP = 2'b10
  } load_state_e;

  typedef struct packed {
    logic [XW-1:0] v0_x;
    logic [YW-1:0] v0_y;
    logic [XW-1:0] v1_x;
    logic [YW-1:0] v1_y;
    logic [XW-1:0] v2_x;
    logic [YW-1:0] v2_y;
    logic [CW-1:0] color;
    logic [DW-1:0] depth;
    logic          en;
  } poly_desc_t;

  // Opcode field of a header byte
  function automatic logic [1:0] hdr_opcode(input logic [7:0] hdr);
    return hdr[7:6];
  endfunction

endpackage

// File: rtl/poly_cmd_loader_if.sv
// Byte-wide valid/ready command stream feeding the polygon loader.
interface poly_cmd_loader_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/poly_slot_regs.sv
// Shadow + active descriptor pair for one polygon slot. The shadow copy is
// edited byte-by-byte; the active copy only changes on a commit so the
// rasterizer always sees a complete descriptor.
module poly_slot_regs
  import poly_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_idx,
  input  logic [7:0] wr_data,
  input  logic       dis_en,
  input  logic       commit,
  output poly_desc_t active_desc
);

  poly_desc_t shadow_r;
  poly_desc_t shadow_nxt_s;
  poly_desc_t active_r;

  // Next shadow value: one field per data byte, depth byte also enables the slot
  always_comb begin
    shadow_nxt_s = shadow_r;
    if (wr_en) begin
      case (wr_idx)
        3'd0: shadow_nxt_s.v0_x  = wr_data[XW-1:0];
        3'd1: shadow_nxt_s.v0_y  = wr_data[YW-1:0];
        3'd2: shadow_nxt_s.v1_x  = wr_data[XW-1:0];
        3'd3: shadow_nxt_s.v1_y  = wr_data[YW-1:0];
        3'd4: shadow_nxt_s.v2_x  = wr_data[XW-1:0];
        3'd5: shadow_nxt_s.v2_y  = wr_data[YW-1:0];
        3'd6: shadow_nxt_s.color = wr_data[CW-1:0];
        3'd7: begin
          shadow_nxt_s.depth = wr_data[DW-1:0];
          shadow_nxt_s.en    = 1'b1;
        end
        default: shadow_nxt_s = shadow_r;
      endcase
    end else if (dis_en) begin
      shadow_nxt_s.en = 1'b0;
    end else begin
      shadow_nxt_s = shadow_r;
    end
  end

  // Shadow descriptor register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r <= '0;
    end else begin
      shadow_r <= shadow_nxt_s;
    end
  end

  // Active descriptor register, loaded whole from the shadow on commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r <= '0;
    end else if (commit) begin
      active_r <= shadow_r;
    end else begin
      active_r <= active_r;
    end
  end

  assign active_desc = active_r;

endmodule

// File: rtl/poly_cmd_loader.sv
// Command front-end for the pixel core: parses the byte stream into shadow
// polygon/background registers and swaps them into the active set only at
// a frame boundary after a COMMIT.
module poly_cmd_loader
  import poly_cfg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  poly_cmd_loader_if.slave      cmd,
  input  logic                  frame_start,
  output logic                  commit_pending,
  output logic                  frame_committed,
  output logic [NUM_POLY-1:0]   cmp_en,
  output logic [CW-1:0]         background_color,
  output logic [2*CW-1:0]       poly_color,
  output logic [2*XW-1:0]       v0_x,
  output logic [2*XW-1:0]       v1_x,
  output logic [2*XW-1:0]       v2_x,
  output logic [2*YW-1:0]       v0_y,
  output logic [2*YW-1:0]       v1_y,
  output logic [2*YW-1:0]       v2_y,
  output logic [2*DW-1:0]       poly_depth
);

  load_state_e         state_r;
  load_state_e         state_nxt_s;
  logic [2:0]          cnt_r;
  logic [2:0]          cnt_nxt_s;
  logic                slot_r;
  logic                slot_nxt_s;
  logic [CW-1:0]       bg_shadow_r;
  logic [CW-1:0]       bg_shadow_nxt_s;
  logic [CW-1:0]       bg_active_r;
  logic                frame_committed_r;
  logic                in_ready_s;
  logic                accept_s;
  logic [1:0]          opcode_s;
  logic [NUM_POLY-1:0] wr_en_s;
  logic [NUM_POLY-1:0] dis_en_s;
  logic                commit_s;
  poly_desc_t          slot_a_s;
  poly_desc_t          slot_b_s;

  // Ready is a pure decode of the state register
  assign in_ready_s   = (state_r != ST_WAIT_SWAP);
  assign cmd.in_ready = in_ready_s;
  assign accept_s     = cmd.in_valid && in_ready_s;
  assign opcode_s     = hdr_opcode(cmd.in_data);

  // Next-state, byte-routing and commit decode
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    slot_nxt_s      = slot_r;
    bg_shadow_nxt_s = bg_shadow_r;
    wr_en_s         = {NUM_POLY{1'b0}};
    dis_en_s        = {NUM_POLY{1'b0}};
    commit_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (opcode_s)
            OP_SET_BG: begin
              bg_shadow_nxt_s = cmd.in_data[CW-1:0];
            end
            OP_WRITE_POLY: begin
              slot_nxt_s  = cmd.in_data[0];
              cnt_nxt_s   = 3'd0;
              state_nxt_s = ST_DATA;
            end
            OP_DISABLE: begin
              dis_en_s[cmd.in_data[0]] = 1'b1;
            end
            OP_COMMIT: begin
              // frame_start in this same cycle is deliberately not honoured
              state_nxt_s = ST_WAIT_SWAP;
            end
            default: begin
              state_nxt_s = ST_IDLE;
            end
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          wr_en_s[slot_r] = 1'b1;
          if (cnt_r == LAST_DATA_IDX) begin
            cnt_nxt_s   = 3'd0;
            state_nxt_s = ST_IDLE;
          end else begin
            cnt_nxt_s = cnt_r + 3'd1;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_WAIT_SWAP: begin
        if (frame_start) begin
          commit_s    = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_SWAP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 3'd0;
      end
    endcase
  end

  // Loader state, data-byte counter, target slot and shadow background
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 3'd0;
      slot_r      <= 1'b0;
      bg_shadow_r <= {CW{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      slot_r      <= slot_nxt_s;
      bg_shadow_r <= bg_shadow_nxt_s;
    end
  end

  // Active background and the one-cycle post-swap pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bg_active_r       <= {CW{1'b0}};
      frame_committed_r <= 1'b0;
    end else begin
      bg_active_r       <= commit_s ? bg_shadow_r : bg_active_r;
      frame_committed_r <= commit_s;
    end
  end

  poly_slot_regs u_slot_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en_s[0]),
    .wr_idx      (cnt_r),
    .wr_data     (cmd.in_data),
    .dis_en      (dis_en_s[0]),
    .commit      (commit_s),
    .active_desc (slot_a_s)
  );

  poly_slot_regs u_slot_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en_s[1]),
    .wr_idx      (cnt_r),
    .wr_data     (cmd.in_data),
    .dis_en      (dis_en_s[1]),
    .commit      (commit_s),
    .active_desc (slot_b_s)
  );

  // Slot 0 in the low half, slot 1 in the high half of every packed bus
  assign commit_pending   = (state_r == ST_WAIT_SWAP);
  assign frame_committed  = frame_committed_r;
  assign background_color = bg_active_r;
  assign cmp_en           = {slot_b_s.en, slot_a_s.en};
  assign poly_color       = {slot_b_s.color, slot_a_s.color};
  assign v0_x             = {slot_b_s.v0_x, slot_a_s.v0_x};
  assign v1_x             = {slot_b_s.v1_x, slot_a_s.v1_x};
  assign v2_x             = {slot_b_s.v2_x, slot_a_s.v2_x};
  assign v0_y             = {slot_b_s.v0_y, slot_a_s.v0_y};
  assign v1_y             = {slot_b_s.v1_y, slot_a_s.v1_y};
  assign v2_y             = {slot_b_s.v2_y, slot_a_s.v2_y};
  assign poly_depth       = {slot_b_s.depth, slot_a_s.depth};

endmodule

// File: tb/tb_poly_cmd_loader.sv
// Directed + randomized bench for poly_cmd_loader with a command-level
// reference model of the shadow/active register sets.
module tb_poly_cmd_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        commit_pending;
  logic        frame_committed;
  logic [1:0]  cmp_en;
  logic [5:0]  background_color;
  logic [11:0] poly_color;
  logic [13:0] v0_x, v1_x, v2_x;
  logic [11:0] v0_y, v1_y, v2_y;
  logic [5:0]  poly_depth;

  poly_cmd_loader_if cmd_if ();

  poly_cmd_loader dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd              (cmd_if),
    .frame_start      (frame_start),
    .commit_pending   (commit_pending),
    .frame_committed  (frame_committed),
    .cmp_en           (cmp_en),
    .background_color (background_color),
    .poly_color       (poly_color),
    .v0_x             (v0_x),
    .v1_x             (v1_x),
    .v2_x             (v2_x),
    .v0_y             (v0_y),
    .v1_y             (v1_y),
    .v2_y             (v2_y),
    .poly_depth       (poly_depth)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: shadow (sh) and active (ac) copies, index [slot][vertex]
  logic [6:0] sh_x [2][3];
  logic [5:0] sh_y [2][3];
  logic [5:0] sh_col [2];
  logic [2:0] sh_dep [2];
  logic       sh_en [2];
  logic [5:0] sh_bg;
  logic [6:0] ac_x [2][3];
  logic [5:0] ac_y [2][3];
  logic [5:0] ac_col [2];
  logic [2:0] ac_dep [2];
  logic       ac_en [2];
  logic [5:0] ac_bg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_checks++;
    n_fail++;
    $error("FAIL %s observed=timeout expected=in_ready", tag);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 3; v++) begin
        sh_x[s][v] = 7'd0; sh_y[s][v] = 6'd0;
        ac_x[s][v] = 7'd0; ac_y[s][v] = 6'd0;
      end
      sh_col[s] = 6'd0; sh_dep[s] = 3'd0; sh_en[s] = 1'b0;
      ac_col[s] = 6'd0; ac_dep[s] = 3'd0; ac_en[s] = 1'b0;
    end
    sh_bg = 6'd0;
    ac_bg = 6'd0;
  endtask

  task automatic model_swap();
    ac_x = sh_x; ac_y = sh_y; ac_col = sh_col; ac_dep = sh_dep; ac_en = sh_en;
    ac_bg = sh_bg;
  endtask

  task automatic model_write(input int s, input logic [7:0] d [8]);
    for (int v = 0; v < 3; v++) begin
      sh_x[s][v] = d[2*v][6:0];
      sh_y[s][v] = d[2*v+1][5:0];
    end
    sh_col[s] = d[6][5:0];
    sh_dep[s] = d[7][2:0];
    sh_en[s]  = 1'b1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".cmp_en"}, cmp_en, {ac_en[1], ac_en[0]});
    chk({tag, ".bg"}, background_color, ac_bg);
    chk({tag, ".color"}, poly_color, {ac_col[1], ac_col[0]});
    chk({tag, ".v0_x"}, v0_x, {ac_x[1][0], ac_x[0][0]});
    chk({tag, ".v1_x"}, v1_x, {ac_x[1][1], ac_x[0][1]});
    chk({tag, ".v2_x"}, v2_x, {ac_x[1][2], ac_x[0][2]});
    chk({tag, ".v0_y"}, v0_y, {ac_y[1][0], ac_y[0][0]});
    chk({tag, ".v1_y"}, v1_y, {ac_y[1][1], ac_y[0][1]});
    chk({tag, ".v2_y"}, v2_y, {ac_y[1][2], ac_y[0][2]});
    chk({tag, ".depth"}, poly_depth, {ac_dep[1], ac_dep[0]});
  endtask

  // Present a byte and hold it until the loader takes it (bounded wait)
  task automatic send_byte(input logic [7:0] b);
    int budget;
    @(negedge clk);
    cmd_if.in_valid = 1'b1;
    cmd_if.in_data  = b;
    budget = 0;
    while (cmd_if.in_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) begin
      timeout_fail("send_byte");
      cmd_if.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 cmd_if.in_valid = 1'b0;
    end
  endtask

  task automatic send_write_poly(input int s, input logic [7:0] d [8]);
    logic [4:0] junk;
    junk = 5'($urandom);
    send_byte({2'b01, junk, 1'(s)});
    for (int i = 0; i < 8; i++) send_byte(d[i]);
    model_write(s, d);
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  task automatic commit_and_swap(input string tag);
    send_byte(8'hC0);
    @(negedge clk);
    chk({tag, ".pending"}, commit_pending, 1'b1);
    chk({tag, ".ready_low"}, cmd_if.in_ready, 1'b0);
    pulse_frame();
    model_swap();
    @(negedge clk);
    chk({tag, ".committed"}, frame_committed, 1'b1);
    check_all(tag);
    @(negedge clk);
    chk({tag, ".committed_off"}, frame_committed, 1'b0);
    chk({tag, ".pending_off"}, commit_pending, 1'b0);
  endtask

  initial begin
    logic [7:0] dat [8];
    logic [7:0] hdr;
    logic [5:0] old_bg;
    int op;

    cmd_if.in_valid = 1'b0;
    cmd_if.in_data  = 8'h00;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check_all("reset");
    chk("reset.in_ready", cmd_if.in_ready, 1'b1);
    chk("reset.pending", commit_pending, 1'b0);
    chk("reset.committed", frame_committed, 1'b0);
    rst_n = 1'b1;

    // Slot 0 load and commit
    dat = '{8'h0A, 8'h05, 8'h40, 8'h05, 8'h20, 8'h30, 8'h30, 8'h03};
    send_byte(8'h40);
    for (int i = 0; i < 8; i++) send_byte(dat[i]);
    model_write(0, dat);
    commit_and_swap("slot0");
    chk("slot0.v0_x_const", v0_x, 14'h000A);
    chk("slot0.v0_y_const", v0_y, 12'h005);
    chk("slot0.v1_x_const", v1_x, 14'h0040);
    chk("slot0.color_const", poly_color, 12'h030);
    chk("slot0.depth_const", poly_depth, 6'o03);
    chk("slot0.cmp_en_const", cmp_en, 2'b01);

    // Slot 1 load with frame_start during DATA and in IDLE: no visible change
    dat = '{8'hFF, 8'h11, 8'h22, 8'h2A, 8'h15, 8'h3F, 8'hCC, 8'h05};
    send_byte(8'h7F);
    for (int i = 0; i < 4; i++) send_byte(dat[i]);
    pulse_frame();
    @(negedge clk);
    chk("fs_data.committed", frame_committed, 1'b0);
    check_all("fs_data");
    for (int i = 4; i < 8; i++) send_byte(dat[i]);
    model_write(1, dat);
    pulse_frame();
    @(negedge clk);
    chk("fs_idle.committed", frame_committed, 1'b0);
    chk("fs_idle.pending", commit_pending, 1'b0);
    check_all("fs_idle");
    commit_and_swap("slot1");
    chk("slot1.v0_x_hi", v0_x[13:7], 7'h7F);
    chk("slot1.cmp_en_const", cmp_en, 2'b11);
    chk("slot1.color_hi", poly_color[11:6], 6'h0C);

    // SET_BG held while waiting for the swap is not taken until after it
    send_byte(8'hC0);
    @(negedge clk);
    cmd_if.in_valid = 1'b1;
    cmd_if.in_data  = 8'h2A;
    repeat (3) begin
      @(negedge clk);
      chk("hold.ready_low", cmd_if.in_ready, 1'b0);
    end
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    model_swap();
    @(negedge clk);
    chk("hold.ready_high", cmd_if.in_ready, 1'b1);
    chk("hold.committed", frame_committed, 1'b1);
    @(posedge clk);
    #1 cmd_if.in_valid = 1'b0;
    sh_bg = 6'h2A;
    @(negedge clk);
    check_all("hold.bg_old");
    commit_and_swap("hold2");
    chk("hold2.bg_const", background_color, 6'h2A);

    // COMMIT accepted in the same cycle as frame_start does not swap
    send_byte(8'h15);
    sh_bg = 6'h15;
    @(negedge clk);
    cmd_if.in_valid = 1'b1;
    cmd_if.in_data  = 8'hC0;
    frame_start     = 1'b1;
    @(posedge clk);
    #1;
    cmd_if.in_valid = 1'b0;
    frame_start     = 1'b0;
    @(negedge clk);
    chk("same.pending", commit_pending, 1'b1);
    chk("same.committed", frame_committed, 1'b0);
    check_all("same.noswap");
    pulse_frame();
    model_swap();
    @(negedge clk);
    chk("same.committed2", frame_committed, 1'b1);
    chk("same.bg", background_color, 6'h15);
    check_all("same.swap");

    // Randomized command mix
    for (int it = 0; it < 25; it++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0: begin
          hdr = {2'b00, 6'($urandom)};
          send_byte(hdr);
          sh_bg = hdr[5:0];
        end
        1: begin
          for (int i = 0; i < 8; i++) dat[i] = 8'($urandom);
          send_write_poly(int'($urandom_range(0, 1)), dat);
        end
        2: begin
          hdr = {2'b10, 6'($urandom)};
          send_byte(hdr);
          sh_en[hdr[0]] = 1'b0;
        end
        default: commit_and_swap("rand");
      endcase
    end
    commit_and_swap("rand_final");

    // Reset in the middle of a WRITE_POLY discards everything
    send_byte(8'h41);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("midrst");
    chk("midrst.in_ready", cmd_if.in_ready, 1'b1);
    chk("midrst.pending", commit_pending, 1'b0);
    rst_n = 1'b1;
    commit_and_swap("postrst");
    chk("postrst.cmp_en_const", cmp_en, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
